spm_ctrl: RTL and testbench

//   Host-side controller for the serial/parallel multiplier array (spm).
//   - Accepts a signed operand pair over a valid/ready handshake.
//   - Holds the multiplicand A parallel on spm_x.
//   - Streams the multiplier B serially, LSB first and sign-extended, on spm_y.
//   - Deserializes the spm_p bit stream into a 2*SIZE-bit two's-complement product.
//   - Returns the product over a valid/ready handshake.
//   - Sits between the bus-side register block and the spm instance; drives all spm inputs.

---
 rtl/spm_ctrl.sv | 122 ++++++++++++
 tb/tb_spm_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spm_ctrl.sv
// Host-side controller for the serial/parallel multiplier array.
// Latches a signed operand pair, streams B serially into the array, and collects the serial product.
`timescale 1ns/1ps

module spm_ctrl #(
    parameter int SIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     in_a,
    input  logic [SIZE-1:0]     in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   out_p,
    output logic                spm_rst,
    output logic [SIZE-1:0]     spm_x,
    output logic                spm_y,
    input  logic                spm_p
);

    localparam int            CW   = $clog2(2*SIZE);
    localparam logic [CW-1:0] LAST = CW'(2*SIZE-1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [SIZE-1:0]     r_b;
    logic [2*SIZE-1:0]   r_p;
    logic [SIZE-1:0]     r_spm_x;
    logic                r_spm_y;
    logic                r_spm_rst;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [2*SIZE-1:0]   w_p_shifted;

    // The array returns product bit k one cycle after it sees multiplier bit k,
    // so bits arrive LSB first and are pushed in at the MSB end.
    assign w_p_shifted = {spm_p, r_p[2*SIZE-1:1]};

    // NOTE: every register below is updated with <= so all of them sample the
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_b         <= '0;
            r_p         <= '0;
            r_spm_x     <= '0;
            r_spm_y     <= 1'b0;
            r_spm_rst   <= 1'b1;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= SHIFT;
                        r_in_ready <= 1'b0;
                        r_spm_rst  <= 1'b0;
                        r_spm_x    <= in_a;
                        r_spm_y    <= in_b[0];
                        r_b        <= $signed(in_b) >>> 1;
                        r_cnt      <= '0;
                        r_p        <= '0;
                    end
                end

                SHIFT: begin
                    // NOTE: arithmetic shift keeps replicating the sign bit, which
                    // supplies the sign extension of B for counts >= SIZE.
                    r_b     <= $signed(r_b) >>> 1;
                    r_spm_y <= (r_cnt == LAST) ? 1'b0 : r_b[0];
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt != '0) begin
                        r_p <= w_p_shifted;
                    end
                    if (r_cnt == LAST) begin
                        r_state <= DRAIN;
                    end
                end

                DRAIN: begin
                    r_p         <= w_p_shifted;
                    r_state     <= DONE;
                    r_out_valid <= 1'b1;
                    r_spm_rst   <= 1'b1;
                end

                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_spm_rst   <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_p     = r_p;
    assign spm_rst   = r_spm_rst;
    assign spm_x     = r_spm_x;
    assign spm_y     = r_spm_y;

endmodule

// File: tb/tb_spm_ctrl.sv
// Self-checking bench for spm_ctrl: behavioural spm array models, a product scoreboard,
// directed SIZE=32 cases and an exhaustive back-to-back SIZE=4 sweep.
`timescale 1ns/1ps

module tb_spm_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, spm_x;
    logic [63:0] out_p;
    logic        spm_rst, spm_y, spm_p;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  in_a4, in_b4, spm_x4;
    logic [7:0]  out_p4;
    logic        spm_rst4, spm_y4, spm_p4;

    spm_ctrl #(.SIZE(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .spm_rst(spm_rst), .spm_x(spm_x), .spm_y(spm_y), .spm_p(spm_p)
    );

    spm_ctrl #(.SIZE(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_p(out_p4),
        .spm_rst(spm_rst4), .spm_x(spm_x4), .spm_y(spm_y4), .spm_p(spm_p4)
    );

    // Array models: accumulate x*y_k*2^k and emit bit k one cycle after y_k is presented.
    logic [63:0] m_acc, m_sum;
    logic [6:0]  m_k;
    assign m_sum = m_acc + (spm_y ? ({{32{spm_x[31]}}, spm_x} << m_k) : 64'd0);
    always @(posedge clk) begin
        if (spm_rst) begin
            m_acc <= '0; m_k <= '0; spm_p <= 1'b0;
        end else begin
            m_acc <= m_sum;
            m_k   <= m_k + 7'd1;
            spm_p <= (m_k < 7'd64) ? m_sum[m_k[5:0]] : 1'b0;
        end
    end

    logic [7:0] m4_acc, m4_sum;
    logic [3:0] m4_k;
    assign m4_sum = m4_acc + (spm_y4 ? ({{4{spm_x4[3]}}, spm_x4} << m4_k) : 8'd0);
    always @(posedge clk) begin
        if (spm_rst4) begin
            m4_acc <= '0; m4_k <= '0; spm_p4 <= 1'b0;
        end else begin
            m4_acc <= m4_sum;
            m4_k   <= m4_k + 4'd1;
            spm_p4 <= (m4_k < 4'd8) ? m4_sum[m4_k[2:0]] : 1'b0;
        end
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb32[$];
    logic [7:0]  sb4[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!in_ready && guard < 300) begin
            tick();
            guard++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        sb32.push_back(64'(longint'($signed(a)) * longint'($signed(b))));
        tick();
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    // Entered in the cycle after the accept; lat counts cycles from the accept cycle.
    task automatic recv32(input string tag, input int hold, input logic [31:0] a, output int lat);
        logic [63:0] exp;
        check({tag, "_busy"}, 64'(in_ready), 64'd0);
        lat = 1;
        while (!out_valid && lat < 300) begin
            tick();
            lat++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        exp = sb32.pop_front();
        check({tag, "_prod"}, out_p, exp);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_a     = ~a;
            in_b     = 32'h0000_0003;
            tick();
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
            check({tag, "_hold_prod"}, out_p, exp);
            check({tag, "_hold_x"}, 64'(spm_x), 64'(a));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vdrop"}, 64'(out_valid), 64'd0);
        check({tag, "_rrise"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int          lat;
        int          sent, got, cyc, last_cyc;
        logic [31:0] ra, rb;
        logic signed [3:0] sa, sbv;
        int          e4;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; in_a4 = '0; in_b4 = '0;
        #2 rst = 1'b0;
        tick();
        tick();
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_p",     out_p,          64'd0);
        check("rst_spm_x",     64'(spm_x),     64'd0);
        check("rst_spm_y",     64'(spm_y),     64'd0);
        check("rst_spm_rst",   64'(spm_rst),   64'd1);
        check("rst4_in_ready", 64'(in_ready4), 64'd1);
        check("rst4_out_p",    64'(out_p4),    64'd0);
        rst = 1'b1;
        tick();

        // Basic product and latency
        send32(32'd3, 32'd5);
        recv32("t1", 0, 32'd3, lat);
        check("t1_latency", 64'(lat), 64'd66);
        check("t1_value", out_p, 64'h0000_0000_0000_000F);

        send32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        recv32("t2a", 0, 32'hFFFF_FFFF, lat);
        check("t2a_value", out_p, 64'd1);
        send32(32'h7FFF_FFFF, 32'hFFFF_FFFF);
        recv32("t2b", 0, 32'h7FFF_FFFF, lat);
        check("t2b_value", out_p, 64'hFFFF_FFFF_8000_0001);

        send32(32'h8000_0000, 32'h8000_0000);
        recv32("t3a", 0, 32'h8000_0000, lat);
        check("t3a_value", out_p, 64'h4000_0000_0000_0000);
        send32(32'd0, 32'hFFFF_FFF9);
        recv32("t3b", 0, 32'd0, lat);
        check("t3b_value", out_p, 64'd0);

        // Backpressure: product held, new request ignored
        send32(32'h0000_1234, 32'hFFFF_FFAB);
        recv32("t4", 10, 32'h0000_1234, lat);

        // Reset in the middle of SHIFT (k=17)
        send32(32'h0001_3579, 32'h0002_468A);
        for (int i = 0; i < 17; i++) tick();
        check("t5_shifting", 64'(spm_rst), 64'd0);
        rst = 1'b0;
        sb32.delete();
        tick();
        check("t5_in_ready",  64'(in_ready),  64'd1);
        check("t5_spm_rst",   64'(spm_rst),   64'd1);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_out_p",     out_p,          64'd0);
        rst = 1'b1;
        tick();
        send32(32'd6, 32'hFFFF_FFF9);
        recv32("t5b", 0, 32'd6, lat);
        check("t5b_value", out_p, 64'hFFFF_FFFF_FFFF_FFD6);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            send32(ra, rb);
            recv32("rand", 0, ra, lat);
        end

        // SIZE=4 exhaustive sweep, in_valid and out_ready held high
        in_valid4  = 1'b1;
        out_ready4 = 1'b1;
        sent = 0; got = 0; cyc = 0; last_cyc = -1;
        while (got < 256 && cyc < 4000) begin
            check("s4_overlap", 64'(in_ready4 & out_valid4), 64'd0);
            if (out_valid4) begin
                check("s4_prod", 64'(out_p4), 64'(sb4.pop_front()));
                if (last_cyc >= 0) check("s4_spacing", 64'(cyc - last_cyc), 64'd11);
                last_cyc = cyc;
                got++;
            end
            if (in_ready4) begin
                if (sent < 256) begin
                    in_a4 = sent[7:4];
                    in_b4 = sent[3:0];
                    sa    = in_a4;
                    sbv   = in_b4;
                    e4    = int'(sa) * int'(sbv);
                    sb4.push_back(e4[7:0]);
                    sent++;
                end else begin
                    in_valid4 = 1'b0;
                end
            end
            tick();
            cyc++;
        end
        in_valid4 = 1'b0;
        check("s4_count", 64'(got), 64'd256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
